mem_ctrl: RTL

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 47 ++++
 rtl/mem_ctrl_if.sv | 30 +++
 rtl/mem_ctrl_ext.sv | 22 ++
 rtl/mem_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg -- shared constants for the byte-serial memory controller.
//   LOAD_TYPE_NUM_WIDTH / ROB_SIZE_WIDTH : widths of load-type and ROB tag fields
//   LD_* / ST_*                          : load and store type encodings
//   IO_ADDR_*                            : UART addresses subject to the optional IO stall
//   state_t                              : controller FSM state encoding
//   load_len / store_len                 : access length in bytes for a type code
package mem_ctrl_pkg;

    localparam int LOAD_TYPE_NUM_WIDTH = 3;
    localparam int ROB_SIZE_WIDTH      = 4;

    localparam logic [LOAD_TYPE_NUM_WIDTH-1:0] LD_LB  = 3'd0;
    localparam logic [LOAD_TYPE_NUM_WIDTH-1:0] LD_LH  = 3'd1;
    localparam logic [LOAD_TYPE_NUM_WIDTH-1:0] LD_LW  = 3'd2;
    localparam logic [LOAD_TYPE_NUM_WIDTH-1:0] LD_LBU = 3'd3;
    localparam logic [LOAD_TYPE_NUM_WIDTH-1:0] LD_LHU = 3'd4;

    localparam logic [1:0] ST_SB = 2'd0;
    localparam logic [1:0] ST_SH = 2'd1;
    localparam logic [1:0] ST_SW = 2'd2;

    localparam logic [31:0] IO_ADDR_0 = 32'h0003_0000;
    localparam logic [31:0] IO_ADDR_1 = 32'h0003_0004;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    function automatic logic [2:0] load_len(input logic [LOAD_TYPE_NUM_WIDTH-1:0] t);
        case (t)
            LD_LB, LD_LBU: load_len = 3'd1;
            LD_LH, LD_LHU: load_len = 3'd2;
            default:       load_len = 3'd4;
        endcase
    endfunction

    function automatic logic [2:0] store_len(input logic [1:0] t);
        case (t)
            ST_SB:   store_len = 3'd1;
            ST_SH:   store_len = 3'd2;
            default: store_len = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if -- byte-wide RAM bus between the controller and the memory/UART.
//   mem_din        : read byte returned by memory (one cycle after mem_a)
//   mem_dout       : write byte
//   mem_a          : byte address
//   mem_wr         : write strobe
//   io_buffer_full : UART transmit buffer full
// master = controller side, slave = memory side.
interface mem_ctrl_if;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    modport master (
        input  mem_din,
        input  io_buffer_full,
        output mem_dout,
        output mem_a,
        output mem_wr
    );

    modport slave (
        output mem_din,
        output io_buffer_full,
        input  mem_dout,
        input  mem_a,
        input  mem_wr
    );
endinterface

// File: rtl/mem_ctrl_ext.sv
// mem_ext_unit -- combinational sign/zero extension of an assembled load word.
//   load_type : load type code (LB/LH/LW/LBU/LHU)
//   raw       : little-endian word assembled from RAM bytes
//   value     : extended result
module mem_ext_unit
    import mem_ctrl_pkg::*;
(
    input  logic [LOAD_TYPE_NUM_WIDTH-1:0] load_type,
    input  logic [31:0]                    raw,
    output logic [31:0]                    value
);
    always_comb begin
        value = raw;
        case (load_type)
            LD_LB:   value = {{24{raw[7]}}, raw[7:0]};
            LD_LH:   value = {{16{raw[15]}}, raw[15:0]};
            LD_LBU:  value = {24'd0, raw[7:0]};
            LD_LHU:  value = {16'd0, raw[15:0]};
            default: value = raw;
        endcase
    end
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl -- byte-serial memory controller arbitrating store, load and ifetch.
//   clk_in / rst_in (sync, active low) / rdy_in (low freezes everything)
//   bus            : RAM bus (mem_ctrl_if.master)
//   if_*           : instruction fetch, level request, one-cycle if_done
//   lb2mem_* / mem_*: load request pulse and result pulse with ROB tag echo
//   st_*           : store request pulse and st_done pulse
//   need_flush_in  : drops pending/in-flight reads, stores are untouched
// Optional: define MEM_CTRL_IO_STALL_EN to hold stores to the UART addresses
// while io_buffer_full is high.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           rdy_in,
    mem_ctrl_if.master                     bus,
    input  logic                           if_req,
    input  logic [31:0]                    if_addr,
    output logic                           if_done,
    output logic [31:0]                    if_inst,
    input  logic                           lb2mem_ready,
    input  logic [LOAD_TYPE_NUM_WIDTH-1:0] lb2mem_load_type,
    input  logic [31:0]                    lb2mem_addr,
    input  logic [ROB_SIZE_WIDTH-1:0]      lb2mem_dependency,
    output logic                           mem_valid,
    output logic [ROB_SIZE_WIDTH-1:0]      mem_dependency,
    output logic [31:0]                    mem_value,
    output logic                           mem_busy,
    input  logic                           st_valid,
    input  logic [1:0]                     st_type,
    input  logic [31:0]                    st_addr,
    input  logic [31:0]                    st_value,
    output logic                           st_done,
    output logic                           st_busy,
    input  logic                           need_flush_in
);
    state_t state_reg, state_next;

    logic [2:0]  cnt_reg, len_reg;
    logic        rd_is_load_reg;
    logic [31:0] rd_buf_reg, rd_word, ext_value;
    logic [31:0] mem_a_reg;
    logic [7:0]  mem_dout_reg, st_byte_next;
    logic        mem_wr_reg;

    logic        st_pend_reg;
    logic [1:0]  st_type_reg;
    logic [31:0] st_addr_reg, st_value_reg;

    logic                           ld_pend_reg;
    logic [LOAD_TYPE_NUM_WIDTH-1:0] ld_type_reg;
    logic [31:0]                    ld_addr_reg;
    logic [ROB_SIZE_WIDTH-1:0]      ld_dep_reg;

    logic                      if_done_reg, mem_valid_reg, st_done_reg;
    logic [31:0]               if_inst_reg, mem_value_reg;
    logic [ROB_SIZE_WIDTH-1:0] mem_dep_reg;

    // A request pulse may be granted in the very cycle it arrives, so the
    // arbiter looks at the latch or, if empty, the live request inputs.
    logic                           st_req, ld_req, st_stall;
    logic [1:0]                     st_eff_type;
    logic [31:0]                    st_eff_addr, st_eff_value, ld_eff_addr;
    logic [LOAD_TYPE_NUM_WIDTH-1:0] ld_eff_type;
    logic                           grant_st, grant_ld, grant_if;
    logic                           rd_last, wr_last;

    assign st_req       = st_pend_reg | st_valid;
    assign st_eff_type  = st_pend_reg ? st_type_reg  : st_type;
    assign st_eff_addr  = st_pend_reg ? st_addr_reg  : st_addr;
    assign st_eff_value = st_pend_reg ? st_value_reg : st_value;
    assign ld_req       = (ld_pend_reg | lb2mem_ready) & ~need_flush_in;
    assign ld_eff_type  = ld_pend_reg ? ld_type_reg : lb2mem_load_type;
    assign ld_eff_addr  = ld_pend_reg ? ld_addr_reg : lb2mem_addr;

`ifdef MEM_CTRL_IO_STALL_EN
    assign st_stall = bus.io_buffer_full &
                      ((st_eff_addr == IO_ADDR_0) || (st_eff_addr == IO_ADDR_1));
`else
    logic io_full_unused;
    assign io_full_unused = bus.io_buffer_full;
    assign st_stall       = 1'b0;
`endif

    // Reads take N+1 cycles (last byte arrives one cycle after its address),
    // writes take N cycles.
    assign rd_last = (cnt_reg == len_reg);
    assign wr_last = (cnt_reg == len_reg - 3'd1);

    // Byte lane gi of the word being assembled comes straight from mem_din in
    // the cycle that byte is returned, otherwise from the buffer.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_word[8*gi +: 8] = (cnt_reg == 3'(gi + 1)) ? bus.mem_din
                                                                  : rd_buf_reg[8*gi +: 8];
        end
    endgenerate

    mem_ext_unit u_ext (
        .load_type (ld_type_reg),
        .raw       (rd_word),
        .value     (ext_value)
    );

    always_comb begin
        st_byte_next = st_value_reg[31:24];
        case (cnt_reg)
            3'd0:    st_byte_next = st_value_reg[15:8];
            3'd1:    st_byte_next = st_value_reg[23:16];
            default: st_byte_next = st_value_reg[31:24];
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        grant_st   = 1'b0;
        grant_ld   = 1'b0;
        grant_if   = 1'b0;
        if (rdy_in) begin
            case (state_reg)
                IDLE: begin
                    if (st_req && !st_stall) begin
                        grant_st   = 1'b1;
                        state_next = WRITE;
                    end else if (ld_req) begin
                        grant_ld   = 1'b1;
                        state_next = READ;
                    end else if (if_req && !if_done_reg && !need_flush_in) begin
                        // if_req is still high in the if_done cycle; don't refetch.
                        grant_if   = 1'b1;
                        state_next = READ;
                    end
                end
                READ:    if (need_flush_in || rd_last) state_next = IDLE;
                WRITE:   if (wr_last) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            cnt_reg        <= 3'd0;
            len_reg        <= 3'd0;
            rd_is_load_reg <= 1'b0;
            rd_buf_reg     <= 32'd0;
            mem_a_reg      <= 32'd0;
            mem_dout_reg   <= 8'd0;
            mem_wr_reg     <= 1'b0;
            st_pend_reg    <= 1'b0;
            st_type_reg    <= 2'd0;
            st_addr_reg    <= 32'd0;
            st_value_reg   <= 32'd0;
            ld_pend_reg    <= 1'b0;
            ld_type_reg    <= '0;
            ld_addr_reg    <= 32'd0;
            ld_dep_reg     <= '0;
            if_done_reg    <= 1'b0;
            mem_valid_reg  <= 1'b0;
            st_done_reg    <= 1'b0;
            if_inst_reg    <= 32'd0;
            mem_value_reg  <= 32'd0;
            mem_dep_reg    <= '0;
        end else if (rdy_in) begin
            if_done_reg   <= 1'b0;
            mem_valid_reg <= 1'b0;
            st_done_reg   <= 1'b0;

            if (st_valid) begin
                st_type_reg  <= st_type;
                st_addr_reg  <= st_addr;
                st_value_reg <= st_value;
            end
            if (grant_st)      st_pend_reg <= 1'b0;
            else if (st_valid) st_pend_reg <= 1'b1;

            if (lb2mem_ready && !need_flush_in) begin
                ld_type_reg <= lb2mem_load_type;
                ld_addr_reg <= lb2mem_addr;
                ld_dep_reg  <= lb2mem_dependency;
            end
            if (need_flush_in || grant_ld) ld_pend_reg <= 1'b0;
            else if (lb2mem_ready)         ld_pend_reg <= 1'b1;

            case (state_reg)
                IDLE: begin
                    cnt_reg <= 3'd0;
                    if (grant_st) begin
                        mem_a_reg    <= st_eff_addr;
                        mem_dout_reg <= st_eff_value[7:0];
                        mem_wr_reg   <= 1'b1;
                        len_reg      <= store_len(st_eff_type);
                    end else if (grant_ld) begin
                        mem_a_reg      <= ld_eff_addr;
                        len_reg        <= load_len(ld_eff_type);
                        rd_is_load_reg <= 1'b1;
                    end else if (grant_if) begin
                        mem_a_reg      <= if_addr;
                        len_reg        <= 3'd4;
                        rd_is_load_reg <= 1'b0;
                    end
                end
                WRITE: begin
                    if (wr_last) begin
                        mem_wr_reg  <= 1'b0;
                        st_done_reg <= 1'b1;
                    end else begin
                        cnt_reg      <= cnt_reg + 3'd1;
                        mem_a_reg    <= mem_a_reg + 32'd1;
                        mem_dout_reg <= st_byte_next;
                    end
                end
                READ: begin
                    rd_buf_reg <= rd_word;
                    cnt_reg    <= cnt_reg + 3'd1;
                    if (need_flush_in) begin
                        // aborted: no result pulse
                    end else if (rd_last) begin
                        if (rd_is_load_reg) begin
                            mem_valid_reg <= 1'b1;
                            mem_value_reg <= ext_value;
                            mem_dep_reg   <= ld_dep_reg;
                        end else begin
                            if_done_reg <= 1'b1;
                            if_inst_reg <= rd_word;
                        end
                    end else if (cnt_reg < len_reg - 3'd1) begin
                        mem_a_reg <= mem_a_reg + 32'd1;
                    end
                end
                default: mem_wr_reg <= 1'b0;
            endcase
        end
    end

    // Pulses are held while frozen and released when rdy_in returns; a flush
    // in the cycle a read result is due swallows it.
    assign if_done        = if_done_reg & rdy_in & ~need_flush_in;
    assign mem_valid      = mem_valid_reg & rdy_in & ~need_flush_in;
    assign st_done        = st_done_reg & rdy_in;
    assign if_inst        = if_inst_reg;
    assign mem_value      = mem_value_reg;
    assign mem_dependency = mem_dep_reg;
    assign mem_busy       = ld_pend_reg | ((state_reg == READ) & rd_is_load_reg);
    assign st_busy        = st_pend_reg | (state_reg == WRITE);

    assign bus.mem_a    = mem_a_reg;
    assign bus.mem_dout = mem_dout_reg;
    assign bus.mem_wr   = mem_wr_reg & rdy_in;
endmodule
